// File: rtl/aes_round_key_expander_if.sv
// Key-in / round-key-half-out streaming bundle for the AES key expander.
// master drives keys and consumes results; slave is the expander itself.
interface aes_round_key_expander_if;
  logic          ivalid;
  logic          oready;
  logic [255:0]  datain;
  logic [7:0]    flagin;
  logic          ovalid;
  logic          iready;
  logic [1023:0] dataout;

  modport master (
    output ivalid, datain, flagin, iready,
    input  oready, ovalid, dataout
  );

  modport slave (
    input  ivalid, datain, flagin, iready,
    output oready, ovalid, dataout
  );
endinterface

// File: rtl/aes_round_key_expander.sv
// AES key schedule expander: one key in, one 1024-bit half of the round-key
// schedule out, one expanded word per cycle.
module aes_round_key_expander #(
  parameter int OPERATION = 0,
  parameter int KEY_WIDTH = 256
) (
  input  logic                       clock,
  input  logic                       reset,
  aes_round_key_expander_if.slave    bus
);

  localparam int unsigned NK  = KEY_WIDTH / 32;
  localparam int unsigned NR  = NK + 6;
  localparam int unsigned NW  = 4 * (NR + 1);
  localparam logic [5:0]  NK6 = 6'(NK);
  localparam logic [5:0]  NW6 = 6'(NW);
  localparam logic [2:0]  PHASE_LAST = 3'(NK - 1);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    sbox_byte = SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    sub_word = {sbox_byte(x[31:24]), sbox_byte(x[23:16]),
                sbox_byte(x[15:8]),  sbox_byte(x[7:0])};
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t        state, state_next;
  logic          accept;
  logic [31:0]   w [NW];
  logic [5:0]    idx;
  logic [2:0]    phase;
  logic [7:0]    rcon;
  logic          half_q;
  logic [31:0]   prev_word, temp, new_word;
  logic [1023:0] dout_next, dataout_q;
  int unsigned   k_idx, r_idx;
  logic [5:0]    base;
  logic          unused_bits;

  assign unused_bits = ^{bus.flagin[7:2], bus.flagin[0], bus.datain};
  assign bus.dataout = dataout_q;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus.oready = (state == IDLE) && !reset;
    bus.ovalid = (state == DONE);
    accept     = bus.ivalid && bus.oready;
    case (state)
      IDLE:    if (accept) state_next = EXPAND;
      EXPAND:  if (idx == NW6) state_next = DONE;
      DONE:    if (bus.iready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // phase tracks i mod Nk and rcon tracks Rcon[i/Nk], so no divider is needed
  always_comb begin
    prev_word = w[idx - 6'd1];
    temp      = prev_word;
    if (phase == 3'd0)
      temp = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h000000};
    else if (NK == 8 && phase == 3'd4)
      temp = sub_word(prev_word);
    new_word = w[idx - NK6] ^ temp;
  end

  always_comb begin
    dout_next = '0;
    k_idx     = 0;
    r_idx     = 0;
    base      = '0;
    for (int unsigned s = 0; s < 8; s++) begin
      k_idx = half_q ? s + 8 : s;
      if (k_idx <= NR) begin
        r_idx = (OPERATION != 0) ? NR - k_idx : k_idx;
        base  = 6'(4 * r_idx);
        dout_next[128*s +: 128] = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
      end
    end
  end

  // One extra EXPAND cycle (idx == NW) packs the finished schedule into dataout
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NW; i++) w[i] <= '0;
      idx       <= '0;
      phase     <= '0;
      rcon      <= '0;
      half_q    <= 1'b0;
      dataout_q <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < NK; i++)
        w[i] <= bus.datain[KEY_WIDTH - 1 - 32*i -: 32];
      half_q <= bus.flagin[1];
      idx    <= NK6;
      phase  <= '0;
      rcon   <= 8'h01;
    end else if (state == EXPAND) begin
      if (idx == NW6) begin
        dataout_q <= dout_next;
      end else begin
        w[idx] <= new_word;
        idx    <= idx + 6'd1;
        phase  <= (phase == PHASE_LAST) ? 3'd0 : phase + 3'd1;
        if (phase == 3'd0)
          rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
    end
  end

endmodule

// File: tb/tb_aes_round_key_expander.sv
// Bench for aes_round_key_expander: four instances (AES-128/192/256 encrypt
// order, AES-128 decrypt order) checked against a FIPS-197 reference model.
module tb_aes_round_key_expander;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0]          ivalid, iready, oready, ovalid;
  logic [3:0][255:0]   datain;
  logic [3:0][7:0]     flagin;
  logic [3:0][1023:0]  dataout;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox [256];
  logic [7:0] rcon_t [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  int nk_of [4] = '{4, 6, 8, 4};
  int op_of [4] = '{0, 0, 0, 1};

  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes_round_key_expander_if bus ();
    assign bus.ivalid  = ivalid[g];
    assign bus.datain  = datain[g];
    assign bus.flagin  = flagin[g];
    assign bus.iready  = iready[g];
    assign oready[g]   = bus.oready;
    assign ovalid[g]   = bus.ovalid;
    assign dataout[g]  = bus.dataout;
    aes_round_key_expander #(
      .OPERATION (g == 3 ? 1 : 0),
      .KEY_WIDTH (g == 1 ? 192 : (g == 2 ? 256 : 128))
    ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
    );
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  function automatic logic [1023:0] model(input int nk, input logic [255:0] key,
                                          input int op, input logic hi);
    logic [31:0]   wm [60];
    logic [31:0]   t;
    logic [1023:0] res;
    int nr = nk + 6;
    int k, r;
    for (int i = 0; i < nk; i++) wm[i] = key[32*nk - 1 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = wm[i-1];
      if (i % nk == 0)
        t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/nk - 1], 24'h0};
      else if (nk == 8 && i % 8 == 4)
        t = subw(t);
      wm[i] = wm[i-nk] ^ t;
    end
    res = '0;
    for (int s = 0; s < 8; s++) begin
      k = hi ? 8 + s : s;
      if (k <= nr) begin
        r = op ? nr - k : k;
        res[128*s +: 128] = {wm[4*r], wm[4*r+1], wm[4*r+2], wm[4*r+3]};
      end
    end
    return res;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input int d, input logic [255:0] din, input logic [7:0] flag);
    @(negedge clock);
    chk($sformatf("u%0d_oready_idle", d), oready[d], 1);
    ivalid[d] = 1'b1;
    datain[d] = din;
    flagin[d] = flag;
    @(posedge clock);
    #1;
    ivalid[d] = 1'b0;
    datain[d] = rand256();
    flagin[d] = 8'($urandom);
  endtask

  task automatic collect(input int d, input logic [1023:0] exp, input bit poke);
    int cyc = 0;
    int lat = 4*(nk_of[d] + 7) - nk_of[d] + 1;
    while (cyc < 200) begin
      @(posedge clock);
      #1;
      cyc++;
      if (poke && cyc == 5) begin
        ivalid[d] = 1'b1;
        datain[d] = rand256();
        flagin[d] = 8'($urandom);
      end
      if (poke && cyc == 15) ivalid[d] = 1'b0;
      if (ovalid[d]) break;
    end
    ivalid[d] = 1'b0;
    chk($sformatf("u%0d_latency", d), cyc, lat);
    for (int s = 0; s < 8; s++)
      chk($sformatf("u%0d_slot%0d", d, s), dataout[d][128*s +: 128], exp[128*s +: 128]);
    chk($sformatf("u%0d_oready_done", d), oready[d], 0);
  endtask

  task automatic release_done(input int d, input int hold, input logic [1023:0] exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clock);
      #1;
      chk($sformatf("u%0d_hold_ovalid", d), ovalid[d], 1);
      chk($sformatf("u%0d_hold_oready", d), oready[d], 0);
      chk($sformatf("u%0d_hold_data", d), dataout[d] === exp, 1);
    end
    @(negedge clock);
    iready[d] = 1'b1;
    @(posedge clock);
    #1;
    iready[d] = 1'b0;
    chk($sformatf("u%0d_rel_ovalid", d), ovalid[d], 0);
    chk($sformatf("u%0d_rel_oready", d), oready[d], 1);
  endtask

  task automatic run_key(input int d, input logic [255:0] din, input logic [7:0] flag,
                         input bit poke, output logic [1023:0] exp);
    exp = model(nk_of[d], din, op_of[d], flag[1]);
    start(d, din, flag);
    collect(d, exp, poke);
  endtask

  logic [7:0]    p, q, x;
  logic [1023:0] exp;
  logic [255:0]  key128, key192, key256;
  int            seen;

  initial begin
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;

    ivalid = '0;
    iready = '0;
    datain = '0;
    flagin = '0;
    key128 = {128'hdeadbeef_cafef00d_01234567_89abcdef, 128'h000102030405060708090a0b0c0d0e0f};
    key192 = {64'h5555aaaa_0f0f0f0f, 192'h000102030405060708090a0b0c0d0e0f1011121314151617};
    key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    repeat (2) @(posedge clock);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("u%0d_rst_oready", d), oready[d], 0);
      chk($sformatf("u%0d_rst_ovalid", d), ovalid[d], 0);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("u%0d_post_rst_oready", d), oready[d], 1);
      chk($sformatf("u%0d_post_rst_ovalid", d), ovalid[d], 0);
      chk($sformatf("u%0d_post_rst_data", d), dataout[d] === '0, 1);
    end

    run_key(0, key128, 8'h01, 1'b0, exp);
    chk("aes128_lo_slot0", dataout[0][127:0],   128'h000102030405060708090a0b0c0d0e0f);
    chk("aes128_lo_slot1", dataout[0][255:128], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    release_done(0, 10, exp);

    run_key(0, key128, 8'h02, 1'b0, exp);
    chk("aes128_hi_slot2", dataout[0][383:256], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("aes128_hi_slot3", dataout[0][511:384], 128'h0);
    chk("aes128_hi_slot7", dataout[0][1023:896], 128'h0);
    release_done(0, 0, exp);

    run_key(2, key256, 8'h01, 1'b0, exp);
    chk("aes256_lo_slot1", dataout[2][255:128], 128'h101112131415161718191a1b1c1d1e1f);
    chk("aes256_lo_slot2", dataout[2][383:256], 128'ha573c29fa176c498a97fce93a572c09c);
    release_done(2, 1, exp);

    run_key(2, key256, 8'h02, 1'b0, exp);
    chk("aes256_hi_slot6", dataout[2][895:768], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    chk("aes256_hi_slot7", dataout[2][1023:896], 128'h0);
    release_done(2, 0, exp);

    run_key(1, key192, 8'h02, 1'b0, exp);
    chk("aes192_hi_slot4", dataout[1][639:512], 128'ha4970a331a78dc09c418c271e3a41d5d);
    release_done(1, 0, exp);

    run_key(3, key128, 8'h01, 1'b0, exp);
    chk("aes128_dec_slot0", dataout[3][127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    release_done(3, 0, exp);

    // ivalid asserted while busy must not disturb the key in flight
    run_key(1, rand256(), 8'($urandom), 1'b1, exp);
    release_done(1, 2, exp);
    run_key(2, rand256(), 8'h03, 1'b1, exp);
    release_done(2, 0, exp);

    for (int d = 0; d < 4; d++)
      for (int n = 0; n < 3; n++) begin
        run_key(d, rand256(), 8'($urandom), 1'b0, exp);
        release_done(d, $urandom_range(0, 3), exp);
      end

    // abort mid-expansion with reset
    start(0, rand256(), 8'h01);
    repeat (20) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_in_rst_ovalid", ovalid[0], 0);
    chk("abort_in_rst_oready", oready[0], 0);
    chk("abort_in_rst_data", dataout[0] === '0, 1);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("abort_ovalid", ovalid[0], 0);
    chk("abort_oready", oready[0], 1);
    chk("abort_data", dataout[0] === '0, 1);
    seen = 0;
    repeat (60) begin
      @(posedge clock);
      #1;
      if (ovalid[0]) seen++;
    end
    chk("abort_no_ovalid", seen, 0);

    run_key(0, rand256(), 8'h02, 1'b0, exp);
    release_done(0, 1, exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
